// File: rtl/l1d_core_lsu_pkg.sv
// Shared core/L1D request definitions: cop and size encodings, bus widths,
// and the address-alignment helpers used by the load/store unit.
package core_pkg;

   localparam int CORE_ADDR_WIDTH = 32;
   localparam int CORE_DATA_WIDTH = 32;
   localparam int CORE_COP_WIDTH  = 1;
   localparam int CORE_SIZE_WIDTH = 2;
   localparam int CORE_BE_WIDTH   = CORE_DATA_WIDTH / 8;

   typedef enum logic [CORE_COP_WIDTH-1:0] {
      COP_RD = 1'b0,
      COP_WR = 1'b1
   } cop_e;

   typedef enum logic [CORE_SIZE_WIDTH-1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } lsu_state_e;

   // Size code 3 is handled as a word everywhere.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic res;
      case (size)
         SZ_B:    res = 1'b0;
         SZ_H:    res = lo[0];
         default: res = (lo != 2'b00);
      endcase
      return res;
   endfunction

   function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
      logic [1:0] res;
      case (size)
         SZ_B:    res = lo;
         SZ_H:    res = {lo[1], 1'b0};
         default: res = 2'b00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/l1d_core_lsu_if.sv
// L1D core request port: request fields driven by the LSU, ack and read
// data returned by the cache.
interface l1d_core_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   import core_pkg::*;

   logic                       core_req_val;
   logic [ADDR_W-1:0]          core_req_addr;
   logic [CORE_COP_WIDTH-1:0]  core_req_cop;
   logic [DATA_W-1:0]          core_req_wdata;
   logic [CORE_SIZE_WIDTH-1:0] core_req_size;
   logic [DATA_W/8-1:0]        core_req_be;
   logic                       core_req_ack;
   logic [DATA_W-1:0]          core_ack_data;

   modport master (
      output core_req_val, core_req_addr, core_req_cop, core_req_wdata,
             core_req_size, core_req_be,
      input  core_req_ack, core_ack_data
   );

   modport slave (
      input  core_req_val, core_req_addr, core_req_cop, core_req_wdata,
             core_req_size, core_req_be,
      output core_req_ack, core_ack_data
   );
endinterface

// File: rtl/l1d_lsu_align.sv
// Combinational lane logic: byte enables and store-lane replication for the
// op being issued, and shift/extension of returned load data.
module l1d_lsu_align
   import core_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]          st_addr_lo,
   input  logic [1:0]          st_size,
   input  logic [DATA_W-1:0]   st_wdata,
   output logic [DATA_W/8-1:0] st_be,
   output logic [DATA_W-1:0]   st_lane_data,
   input  logic [1:0]          ld_addr_lo,
   input  logic [1:0]          ld_size,
   input  logic                ld_unsigned,
   input  logic [DATA_W-1:0]   ld_raw,
   output logic [DATA_W-1:0]   ld_data
);

   logic [DATA_W-1:0] ld_shift;

   // Store side: enables and replicated write data for the outgoing op.
   always_comb begin
      st_be        = 4'b0000;
      st_lane_data = st_wdata;
      case (st_size)
         SZ_B: begin
            st_be        = 4'b0001 << st_addr_lo;
            st_lane_data = {4{st_wdata[7:0]}};
         end
         SZ_H: begin
            st_be        = 4'b0011 << {st_addr_lo[1], 1'b0};
            st_lane_data = {2{st_wdata[15:0]}};
         end
         default: begin
            st_be        = 4'b1111;
            st_lane_data = st_wdata;
         end
      endcase
   end

   // Load side: bring the addressed lane to bit 0, then extend.
   always_comb begin
      ld_shift = ld_raw >> {ld_addr_lo, 3'b000};
      ld_data  = ld_shift;
      case (ld_size)
         SZ_B: begin
            if (ld_unsigned) ld_data = {24'h00_0000, ld_shift[7:0]};
            else             ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         end
         SZ_H: begin
            if (ld_unsigned) ld_data = {16'h0000, ld_shift[15:0]};
            else             ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         end
         default: ld_data = ld_shift;
      endcase
   end

endmodule

// File: rtl/l1d_core_lsu.sv
// Core-side L1D request initiator: one outstanding load/store, registered
// request and writeback. Optional misaligned-access trap: L1D_CORE_LSU_MISALIGN_CHECK_EN.
module l1d_core_lsu
   import core_pkg::*;
#(
   parameter int ADDR_W = CORE_ADDR_WIDTH,
   parameter int DATA_W = CORE_DATA_WIDTH,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_val,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [1:0]        lsu_size,
   input  logic              lsu_unsigned,
   input  logic [RD_W-1:0]   lsu_rd,
   output logic              lsu_stall,
   output logic              lsu_misalign,
   output logic              wb_val,
   output logic [DATA_W-1:0] wb_data,
   output logic [RD_W-1:0]   wb_rd,
   l1d_core_lsu_if.master    core
);

   lsu_state_e          state_r, state_nx;
   logic                accept_s, complete_s, misal_s;
   logic [ADDR_W-1:0]   issue_addr_s;
   logic [DATA_W/8-1:0] be_s;
   logic [DATA_W-1:0]   lane_s, ld_data_s;

   logic                req_val_r, unsigned_r, misalign_r, wb_val_r;
   logic [ADDR_W-1:0]   addr_r;
   cop_e                cop_r;
   logic [DATA_W-1:0]   wdata_r, wb_data_r;
   logic [1:0]          size_r;
   logic [DATA_W/8-1:0] be_r;
   logic [RD_W-1:0]     rd_r, wb_rd_r;

`ifdef L1D_CORE_LSU_MISALIGN_CHECK_EN
   assign misal_s      = is_misaligned(lsu_size, lsu_addr[1:0]);
   assign issue_addr_s = lsu_addr;
`else
   assign misal_s      = 1'b0;
   assign issue_addr_s = {lsu_addr[ADDR_W-1:2], align_lo(lsu_size, lsu_addr[1:0])};
`endif

   l1d_lsu_align #(.DATA_W(DATA_W)) u_align (
      .st_addr_lo   (issue_addr_s[1:0]),
      .st_size      (lsu_size),
      .st_wdata     (lsu_wdata),
      .st_be        (be_s),
      .st_lane_data (lane_s),
      .ld_addr_lo   (addr_r[1:0]),
      .ld_size      (size_r),
      .ld_unsigned  (unsigned_r),
      .ld_raw       (core.core_ack_data),
      .ld_data      (ld_data_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nx;
   end

   // Next state plus accept/complete strobes; an ack in IDLE is ignored.
   always_comb begin
      state_nx   = state_r;
      accept_s   = 1'b0;
      complete_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (lsu_val) begin
               accept_s = 1'b1;
               state_nx = misal_s ? ST_IDLE : ST_REQ;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (core.core_req_ack) begin
               complete_s = 1'b1;
               if (lsu_val) begin
                  accept_s = 1'b1;
                  state_nx = misal_s ? ST_IDLE : ST_REQ;
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               state_nx = ST_REQ;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Request, misalign and writeback registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_val_r  <= 1'b0;
         addr_r     <= '0;
         cop_r      <= COP_RD;
         wdata_r    <= '0;
         size_r     <= 2'b00;
         be_r       <= '0;
         unsigned_r <= 1'b0;
         rd_r       <= '0;
         misalign_r <= 1'b0;
         wb_val_r   <= 1'b0;
         wb_data_r  <= '0;
         wb_rd_r    <= '0;
      end else begin
         misalign_r <= accept_s && misal_s;
         if (accept_s && !misal_s) begin
            req_val_r  <= 1'b1;
            addr_r     <= issue_addr_s;
            cop_r      <= lsu_we ? COP_WR : COP_RD;
            wdata_r    <= lane_s;
            size_r     <= lsu_size;
            be_r       <= be_s;
            unsigned_r <= lsu_unsigned;
            rd_r       <= lsu_rd;
         end else if (complete_s) begin
            req_val_r <= 1'b0;
         end
         wb_val_r <= complete_s && (cop_r == COP_RD);
         if (complete_s && (cop_r == COP_RD)) begin
            wb_data_r <= ld_data_s;
            wb_rd_r   <= rd_r;
         end
      end
   end

   assign lsu_stall           = (state_r == ST_REQ) && !core.core_req_ack;
   assign lsu_misalign        = misalign_r;
   assign wb_val              = wb_val_r;
   assign wb_data             = wb_data_r;
   assign wb_rd               = wb_rd_r;
   assign core.core_req_val   = req_val_r;
   assign core.core_req_addr  = addr_r;
   assign core.core_req_cop   = cop_r;
   assign core.core_req_wdata = wdata_r;
   assign core.core_req_size  = size_r;
   assign core.core_req_be    = be_r;

endmodule

// File: tb/tb_l1d_core_lsu.sv
// Scoreboard bench for l1d_core_lsu: request fields checked per cycle,
// expected writebacks queued at issue and compared when wb_val fires.
module tb_l1d_core_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_val, lsu_we, lsu_unsigned;
   logic [31:0] lsu_addr, lsu_wdata;
   logic [1:0]  lsu_size;
   logic [4:0]  lsu_rd;
   logic        lsu_stall, lsu_misalign, wb_val;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;
   wb_exp_t wb_q[$];

   l1d_core_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   l1d_core_lsu #(.ADDR_W(32), .DATA_W(32), .RD_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .lsu_val      (lsu_val),
      .lsu_we       (lsu_we),
      .lsu_addr     (lsu_addr),
      .lsu_wdata    (lsu_wdata),
      .lsu_size     (lsu_size),
      .lsu_unsigned (lsu_unsigned),
      .lsu_rd       (lsu_rd),
      .lsu_stall    (lsu_stall),
      .lsu_misalign (lsu_misalign),
      .wb_val       (wb_val),
      .wb_data      (wb_data),
      .wb_rd        (wb_rd),
      .core         (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Writeback monitor: every wb_val pulse must match the oldest queued load.
   always @(negedge clk) begin
      if (wb_val) begin
         if (wb_q.size() == 0) begin
            check_val("wb_unexpected", 32'(wb_rd), 32'hFFFF_FFFF);
         end else begin
            wb_exp_t e;
            e = wb_q.pop_front();
            check_val("wb_data", wb_data, e.data);
            check_val("wb_rd", 32'(wb_rd), 32'(e.rd));
         end
      end
   end

   task automatic drive_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input logic [4:0] rd);
      lsu_val = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata;
      lsu_size = size; lsu_unsigned = uns; lsu_rd = rd;
   endtask

   task automatic check_req(input logic [31:0] e_addr, input logic e_cop, input logic [31:0] e_wdata,
                            input logic [3:0] e_be, input logic [1:0] e_size);
      check_val("req_val", 32'(bus.core_req_val), 32'd1);
      check_val("req_addr", bus.core_req_addr, e_addr);
      check_val("req_cop", 32'(bus.core_req_cop), 32'(e_cop));
      check_val("req_be", 32'(bus.core_req_be), 32'(e_be));
      check_val("req_size", 32'(bus.core_req_size), 32'(e_size));
      if (e_cop) check_val("req_wdata", bus.core_req_wdata, e_wdata);
   endtask

   // One op, entered and left at posedge+1; waits = cycles before ack.
   task automatic issue_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input logic [4:0] rd,
                           input int waits, input logic [31:0] ack_data,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic [3:0] e_be, input logic [31:0] e_wb);
      drive_op(we, addr, wdata, size, uns, rd);
      @(posedge clk); #1;
      for (int i = 0; i < waits; i++) begin
         check_req(e_addr, we, e_wdata, e_be, size);
         check_val("stall_wait", 32'(lsu_stall), 32'd1);
         @(posedge clk); #1;
      end
      bus.core_req_ack = 1'b1;
      bus.core_ack_data = ack_data;
      lsu_val = 1'b0;
      #1;
      check_req(e_addr, we, e_wdata, e_be, size);
      check_val("stall_ack", 32'(lsu_stall), 32'd0);
      check_val("misalign_none", 32'(lsu_misalign), 32'd0);
      if (!we) wb_q.push_back('{rd: rd, data: e_wb});
      @(posedge clk); #1;
      bus.core_req_ack = 1'b0;
      check_val("req_val_done", 32'(bus.core_req_val), 32'd0);
      check_val("stall_done", 32'(lsu_stall), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      lsu_val = 1'b0; lsu_we = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
      lsu_size = 2'd0; lsu_unsigned = 1'b0; lsu_rd = 5'd0;
      bus.core_req_ack = 1'b0; bus.core_ack_data = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_req_val", 32'(bus.core_req_val), 32'd0);
      check_val("rst_req_addr", bus.core_req_addr, 32'd0);
      check_val("rst_req_be", 32'(bus.core_req_be), 32'd0);
      check_val("rst_req_wdata", bus.core_req_wdata, 32'd0);
      check_val("rst_wb_val", 32'(wb_val), 32'd0);
      check_val("rst_wb_data", wb_data, 32'd0);
      check_val("rst_stall", 32'(lsu_stall), 32'd0);
      check_val("rst_misalign", 32'(lsu_misalign), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Word store with three wait cycles.
      issue_op(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, 5'd0, 3, 32'h0,
               32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0);
      // Byte loads from the top lane, signed then unsigned.
      issue_op(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 5'd7, 1, 32'h80FF_FFFF,
               32'h103, 32'h0, 4'b1000, 32'hFFFF_FF80);
      issue_op(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 5'd8, 0, 32'h80FF_FFFF,
               32'h103, 32'h0, 4'b1000, 32'h0000_0080);
      // Half store to the upper half and a signed half load from it.
      issue_op(1'b1, 32'h202, 32'h0000_1234, 2'd1, 1'b0, 5'd0, 2, 32'h0,
               32'h202, 32'h1234_1234, 4'b1100, 32'h0);
      issue_op(1'b0, 32'h202, 32'h0, 2'd1, 1'b0, 5'd9, 0, 32'h8001_5555,
               32'h202, 32'h0, 4'b1100, 32'hFFFF_8001);

      // Four back-to-back word loads with zero-wait ack.
      drive_op(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 5'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         bus.core_req_ack = 1'b1;
         bus.core_ack_data = 32'hA000_0000 + 32'(i);
         #1;
         check_val("b2b_req_val", 32'(bus.core_req_val), 32'd1);
         check_val("b2b_addr", bus.core_req_addr, 32'h300 + 32'(4 * i));
         check_val("b2b_stall", 32'(lsu_stall), 32'd0);
         wb_q.push_back('{rd: 5'(i + 1), data: 32'hA000_0000 + 32'(i)});
         if (i < 3) drive_op(1'b0, 32'h300 + 32'(4 * (i + 1)), 32'h0, 2'd2, 1'b0, 5'(i + 2));
         else       lsu_val = 1'b0;
         @(posedge clk); #1;
      end
      bus.core_req_ack = 1'b0;
      check_val("b2b_done", 32'(bus.core_req_val), 32'd0);
      @(posedge clk); #1;

      // Misaligned word load.
`ifdef L1D_CORE_LSU_MISALIGN_CHECK_EN
      drive_op(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 5'd12);
      @(posedge clk); #1;
      lsu_val = 1'b0;
      check_val("mis_pulse", 32'(lsu_misalign), 32'd1);
      check_val("mis_no_req", 32'(bus.core_req_val), 32'd0);
      check_val("mis_no_stall", 32'(lsu_stall), 32'd0);
      @(posedge clk); #1;
      check_val("mis_pulse_end", 32'(lsu_misalign), 32'd0);
      check_val("mis_no_req2", 32'(bus.core_req_val), 32'd0);
`else
      issue_op(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 5'd12, 1, 32'h1122_3344,
               32'h100, 32'h0, 4'hF, 32'h1122_3344);
`endif

      // Reset while a load is outstanding; the late ack must be ignored.
      drive_op(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 5'd20);
      @(posedge clk); #1;
      check_val("rr_req_val", 32'(bus.core_req_val), 32'd1);
      lsu_val = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("rr_req_val_clr", 32'(bus.core_req_val), 32'd0);
      check_val("rr_stall_clr", 32'(lsu_stall), 32'd0);
      check_val("rr_addr_clr", bus.core_req_addr, 32'd0);
      bus.core_req_ack = 1'b1;
      bus.core_ack_data = 32'h5555_AAAA;
      @(posedge clk); #1;
      bus.core_req_ack = 1'b0;
      check_val("rr_no_wb", 32'(wb_val), 32'd0);
      check_val("rr_still_idle", 32'(bus.core_req_val), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      check_val("wb_q_drained", 32'(wb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/l1d_core_lsu.md
# l1d_core_lsu

Core-side initiator for the L1 data cache request interface. Accepts one load/store per cycle from the execute stage and drives it onto the L1D core request port (val/addr/cop/wdata/size/be). It holds each request stable until acknowledged, stalls the pipeline while waiting, and aligns and sign/zero-extends returned load data for writeback. Sits between the core execute stage and the L1D, one request outstanding at a time.

## Interface
Parameters:
- ADDR_W, 32, core address width; equals CORE_ADDR_WIDTH.
- DATA_W, 32, core data width; equals CORE_DATA_WIDTH. BE width is DATA_W/8 = 4.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- lsu_val  in  1  memory op valid from execute.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_addr  in  ADDR_W  byte address.
- lsu_wdata  in  DATA_W  store data, LSB-justified.
- lsu_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- lsu_unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
- lsu_rd  in  RD_W  load destination register.
- lsu_stall  out  1  execute must hold lsu_* stable.
- lsu_misalign  out  1  one-cycle misaligned-access pulse.
- wb_val  out  1  load result valid, one-cycle pulse.
- wb_data  out  DATA_W  extended load data.
- wb_rd  out  RD_W  destination of wb_data.
- core_req_val  out  1  request valid to L1D.
- core_req_addr  out  ADDR_W  request address.
- core_req_cop  out  CORE_COP_WIDTH  RD = 0, WR = 1.
- core_req_wdata  out  DATA_W  lane-replicated store data.
- core_req_size  out  CORE_SIZE_WIDTH  lsu_size, zero-extended.
- core_req_be  out  4  byte enables.
- core_req_ack  in  1  L1D accepts or completes the request.
- core_ack_data  in  DATA_W  read data, valid in the core_req_ack cycle for RD.

## Operation
- FSM has two states: IDLE and REQ.
  - IDLE: lsu_val = 1 accepts the op. Next state is REQ, except a misaligned op with the check enabled, which stays in IDLE.
  - REQ with core_req_ack = 0: stay in REQ.
  - REQ with core_req_ack = 1: complete the op. If lsu_val = 1 in the same cycle, accept the next op and stay in REQ; otherwise go to IDLE.
- lsu_stall = (state == REQ) && !core_req_ack. This is combinational, so execute may present the next op in the ack cycle.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data is replicated across lanes: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
- Load data: core_ack_data >> (8*addr[1:0]), then extend from bit 7/15/31 according to size and lsu_unsigned.
- Loads set wb_val and capture wb_rd from the registered request. Stores never set wb_val.
- An ack seen while in IDLE is ignored.
- Reset applied mid-request:
  - FSM returns to IDLE.
  - All outputs are 0 the next cycle.
  - A late ack for the aborted request produces no writeback.

## Timing
- Reset values of all outputs are 0: core_req_val, all core_req_* fields, wb_val, wb_data, wb_rd, lsu_misalign. lsu_stall is 0 because the FSM is in IDLE.
- core_req_* outputs are registered. An op accepted in cycle N drives core_req_val = 1 from N+1.
- The L1D may ack in N+1 (minimum latency) or any later cycle. All request fields stay stable until the ack cycle inclusive.
- wb_val/wb_data/wb_rd are registered: ack in cycle M gives wb_val = 1 in M+1 for exactly one cycle.
- Back-to-back ops at zero-wait ack sustain one request per cycle, with core_req_val held continuously high.
- lsu_misalign is registered: asserted in N+1 for an op accepted in N.

## Configuration
- Macro: L1D_CORE_LSU_MISALIGN_CHECK_EN.
- Defined: a half with addr[0] = 1, or a word with addr[1:0] != 0, is not issued. lsu_misalign pulses 1 in N+1, with no request and no wb_val.
- Undefined: lsu_misalign is tied to 0. Address low bits are forced to natural alignment (half clears bit 0; word clears bits [1:0]) and the op is issued normally.

## Structure
- Shared package core_pkg holds:
  - the cop enum (COP_RD = 0, COP_WR = 1);
  - the size enum (SZ_B, SZ_H, SZ_W);
  - widths CORE_ADDR_WIDTH, CORE_DATA_WIDTH, CORE_COP_WIDTH, CORE_SIZE_WIDTH, CORE_BE_WIDTH.
- One combinational sub-module, l1d_lsu_align, computes BE, store-lane replication and load extraction/extension. The top holds the FSM and registers.

## Test plan
- Word store, addr 0x100, wdata 0xDEADBEEF, ack after 3 wait cycles:
  - core_req_val high for 4 cycles with be = 4'hF and cop = WR;
  - lsu_stall high for 3 cycles;
  - no wb_val.
- Byte load, addr 0x103, signed, core_ack_data 0x80FF_FFFF:
  - be = 4'b1000;
  - wb_data = 0xFFFFFF80 one cycle after ack.
- Same byte load with lsu_unsigned = 1: wb_data = 0x00000080.
- Half store, addr 0x202, wdata 0x1234: core_req_wdata = 0x12341234, be = 4'b1100.
- Four back-to-back loads with zero-wait ack: core_req_val continuously high for 4 cycles; four wb_val pulses with the correct wb_rd order.
- Word load to addr 0x101:
  - with the macro defined: lsu_misalign pulse and no core_req_val;
  - without it: core_req_addr = 0x100.
- Reset asserted while in REQ: core_req_val = 0 the next cycle, and a subsequent ack yields no wb_val.
